// File: rtl/pdm_pcm_stream_ctrl.sv
// pdm_pcm_stream_ctrl: run-time sequencer for the PDM->PCM decimator core.
// It gates the core enable and drops the filter-settling samples after every
// (re)start. It frames the PCM stream with pcm_last_o and stops only on frame
// boundaries. A core overflow triggers an automatic disable/re-settle cycle.
module pdm_pcm_stream_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int SETTLE_SAMPLES = 8,
  parameter int FRAME_LEN      = 64,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  output logic                  dec_enable_o,
  input  logic                  dec_overflow_i,
  input  logic [DATA_WIDTH-1:0] dec_pcm_data_i,
  input  logic                  dec_pcm_valid_i,
  output logic                  dec_pcm_ready_o,
  output logic [DATA_WIDTH-1:0] pcm_data_o,
  output logic                  pcm_valid_o,
  input  logic                  pcm_ready_i,
  output logic                  pcm_last_o,
  output logic                  frame_abort_o,
  output logic [2:0]            state_o,
  output logic [15:0]           frame_count_o,
  output logic [7:0]            ovf_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  localparam int IW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int SCW = $clog2(SETTLE_SAMPLES + 2);
  localparam int RCW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES + 1) : 1;

  localparam logic [IW-1:0]  IDX_LAST     = IW'(FRAME_LEN - 1);
  localparam logic [SCW-1:0] SETTLE_LAST  = SCW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
  localparam logic [RCW-1:0] RECOVER_LAST = RCW'(RECOVER_CYCLES - 1);
  // With no settling discard, a (re)start goes straight to streaming.
  localparam state_e         RESTART_ST   = (SETTLE_SAMPLES == 0) ? ST_RUN : ST_SETTLE;

  state_e           state_q, state_d;
  logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [IW-1:0]    sample_idx_q, sample_idx_d;
  logic [RCW-1:0]   recover_cnt_q, recover_cnt_d;
  logic             stop_pending_q, stop_pending_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic [7:0]       ovf_count_q, ovf_count_d;
  logic             frame_abort_q, frame_abort_d;

  logic             ovf_hit;
  logic             out_xfer;
  logic             last_hit;

  assign state_o       = state_q;
  assign frame_count_o = frame_count_q;
  assign ovf_count_o   = ovf_count_q;
  assign frame_abort_o = frame_abort_q;

  // Next-state, counter updates and the combinational stream passthrough.
  always_comb begin
    state_d        = state_q;
    settle_cnt_d   = settle_cnt_q;
    sample_idx_d   = sample_idx_q;
    recover_cnt_d  = recover_cnt_q;
    stop_pending_d = stop_pending_q;
    frame_count_d  = frame_count_q;
    ovf_count_d    = ovf_count_q;
    frame_abort_d  = 1'b0;
    dec_enable_o    = 1'b0;
    dec_pcm_ready_o = 1'b0;
    pcm_valid_o     = 1'b0;
    pcm_data_o      = '0;
    pcm_last_o      = 1'b0;
    ovf_hit         = 1'b0;
    out_xfer        = 1'b0;
    last_hit        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous stop cancels the start.
        if (start_i && !stop_i) begin
          state_d      = RESTART_ST;
          settle_cnt_d = '0;
          sample_idx_d = '0;
        end
      end

      ST_SETTLE: begin
        dec_enable_o = 1'b1;
        if (dec_overflow_i) begin
          ovf_hit = 1'b1;
        end else begin
          // Settling samples are accepted from the core and thrown away.
          dec_pcm_ready_o = 1'b1;
          if (stop_i) begin
            state_d = ST_IDLE;
          end else if (dec_pcm_valid_i) begin
            if (settle_cnt_q == SETTLE_LAST) begin
              state_d = ST_RUN;
            end else begin
              settle_cnt_d = settle_cnt_q + 1'b1;
            end
          end
        end
      end

      ST_RUN, ST_DRAIN: begin
        dec_enable_o = 1'b1;
        if (dec_overflow_i) begin
          ovf_hit = 1'b1;
        end else begin
          pcm_valid_o     = dec_pcm_valid_i;
          pcm_data_o      = dec_pcm_data_i;
          dec_pcm_ready_o = pcm_ready_i;
          last_hit        = dec_pcm_valid_i && (sample_idx_q == IDX_LAST);
          pcm_last_o      = last_hit;
          out_xfer        = dec_pcm_valid_i && pcm_ready_i;
          if (out_xfer) begin
            sample_idx_d = (sample_idx_q == IDX_LAST) ? '0 : sample_idx_q + 1'b1;
            if (last_hit) begin
              frame_count_d = frame_count_q + 16'd1;
            end
          end
          if (state_q == ST_RUN) begin
            // Stopping exactly on a boundary with nothing moving needs no drain.
            if (stop_i) begin
              state_d = (sample_idx_q == '0 && !out_xfer) ? ST_IDLE : ST_DRAIN;
            end
          end else if (out_xfer && last_hit) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_RECOVER: begin
        if (recover_cnt_q == RECOVER_LAST) begin
          state_d        = (stop_pending_q || stop_i) ? ST_IDLE : RESTART_ST;
          stop_pending_d = 1'b0;
          settle_cnt_d   = '0;
          recover_cnt_d  = '0;
        end else begin
          recover_cnt_d = recover_cnt_q + 1'b1;
          if (stop_i) begin
            stop_pending_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Overflow outranks stop and start; the partial frame is abandoned.
    if (ovf_hit) begin
      state_d       = ST_RECOVER;
      recover_cnt_d = '0;
      sample_idx_d  = '0;
      frame_abort_d = (sample_idx_q != '0);
      ovf_count_d   = (ovf_count_q == 8'hFF) ? 8'hFF : ovf_count_q + 8'd1;
      if (state_q == ST_DRAIN || stop_i) begin
        stop_pending_d = 1'b1;
      end
    end
  end

  // Control and counter registers, cleared asynchronously.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= ST_IDLE;
      settle_cnt_q   <= '0;
      sample_idx_q   <= '0;
      recover_cnt_q  <= '0;
      stop_pending_q <= 1'b0;
      frame_count_q  <= '0;
      ovf_count_q    <= '0;
      frame_abort_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      sample_idx_q   <= sample_idx_d;
      recover_cnt_q  <= recover_cnt_d;
      stop_pending_q <= stop_pending_d;
      frame_count_q  <= frame_count_d;
      ovf_count_q    <= ovf_count_d;
      frame_abort_q  <= frame_abort_d;
    end
  end

endmodule

// File: tb/tb_pdm_pcm_stream_ctrl.sv
// Bench for pdm_pcm_stream_ctrl: random core traffic and downstream stalls,
// checked against a stream-level model. Each (re)start opens a segment. The
// first SETTLE core transfers of a segment are dropped. Output j of the segment
// must carry core transfer SETTLE+j and is last when j % FRAME == FRAME-1.
module tb_pdm_pcm_stream_ctrl;

  localparam int DW     = 16;
  localparam int SETTLE = 8;
  localparam int FRAME  = 64;
  localparam int RECOV  = 4;

  logic          clk;
  logic          reset_n_i;
  logic          start_i;
  logic          stop_i;
  logic          dec_enable_o;
  logic          dec_overflow_i;
  logic [DW-1:0] dec_pcm_data_i;
  logic          dec_pcm_valid_i;
  logic          dec_pcm_ready_o;
  logic [DW-1:0] pcm_data_o;
  logic          pcm_valid_o;
  logic          pcm_ready_i;
  logic          pcm_last_o;
  logic          frame_abort_o;
  logic [2:0]    state_o;
  logic [15:0]   frame_count_o;
  logic [7:0]    ovf_count_o;

  pdm_pcm_stream_ctrl #(
    .DATA_WIDTH(DW), .SETTLE_SAMPLES(SETTLE), .FRAME_LEN(FRAME), .RECOVER_CYCLES(RECOV)
  ) dut (
    .clock_i(clk), .reset_n_i(reset_n_i), .start_i(start_i), .stop_i(stop_i),
    .dec_enable_o(dec_enable_o), .dec_overflow_i(dec_overflow_i),
    .dec_pcm_data_i(dec_pcm_data_i), .dec_pcm_valid_i(dec_pcm_valid_i),
    .dec_pcm_ready_o(dec_pcm_ready_o), .pcm_data_o(pcm_data_o),
    .pcm_valid_o(pcm_valid_o), .pcm_ready_i(pcm_ready_i), .pcm_last_o(pcm_last_o),
    .frame_abort_o(frame_abort_o), .state_o(state_o),
    .frame_count_o(frame_count_o), .ovf_count_o(ovf_count_o)
  );

  always #5 clk = ~clk;

  int            n_tests;
  int            n_fail;
  logic [DW-1:0] core_seq;
  logic [DW-1:0] core_q[$];
  int            seg_base;
  int            seg_out;
  int            exp_frames;
  int            exp_ovf;
  int            exp_abort;
  logic          s_pvalid;
  logic          s_dready;
  logic          s_last_x;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, sample combinational outputs 2ns later,
  // return 1ns after the following posedge.
  task automatic step(input logic st, input logic sp, input logic ovf);
    int   idx;
    logic cx;
    logic ox;
    @(negedge clk);
    start_i         = st;
    stop_i          = sp;
    dec_overflow_i  = ovf;
    dec_pcm_valid_i = ($urandom_range(0, 9) < 8);
    dec_pcm_data_i  = core_seq;
    pcm_ready_i     = ($urandom_range(0, 3) != 0);
    #2;
    cx       = dec_pcm_valid_i && dec_pcm_ready_o;
    ox       = pcm_valid_o && pcm_ready_i;
    s_pvalid = pcm_valid_o;
    s_dready = dec_pcm_ready_o;
    s_last_x = ox && pcm_last_o;
    if (cx) core_q.push_back(core_seq);
    if (ox) begin
      idx = seg_base + SETTLE + seg_out;
      if (idx < core_q.size()) check_eq("pcm_data", {16'd0, pcm_data_o}, {16'd0, core_q[idx]});
      else check_eq("pcm_unexpected", {31'd0, ox}, 32'd0);
      check_eq("pcm_last", {31'd0, pcm_last_o}, {31'd0, ((seg_out % FRAME) == FRAME - 1)});
      if ((seg_out % FRAME) == FRAME - 1) exp_frames++;
      seg_out++;
    end
    if (cx) core_seq = core_seq + 1'b1;
    @(posedge clk);
    #1;
    start_i        = 1'b0;
    stop_i         = 1'b0;
    dec_overflow_i = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    seg_base = core_q.size();
    seg_out  = 0;
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic wait_idx(input int target);
    int k;
    k = 0;
    while (!(state_o == 3'd2 && (seg_out % FRAME) == target) && k < 3000) begin
      step(1'b0, 1'b0, 1'b0);
      k++;
    end
    check_eq("wait_idx_in_time", {31'd0, (k < 3000)}, 32'd1);
  endtask

  task automatic model_overflow();
    exp_ovf   = (exp_ovf >= 255) ? 255 : exp_ovf + 1;
    exp_abort = ((seg_out % FRAME) != 0) ? 1 : 0;
    seg_base  = core_q.size();
    seg_out   = 0;
  endtask

  task automatic stop_drain(input int target);
    int k;
    bit done;
    wait_idx(target);
    step(1'b0, 1'b1, 1'b0);
    check_eq("drain_state", {29'd0, state_o}, 32'd3);
    k    = 0;
    done = 1'b0;
    while (!done && k < 3000) begin
      step(1'b0, 1'b0, 1'b0);
      k++;
      if (s_last_x) begin
        done = 1'b1;
        check_eq("stop_idle", {29'd0, state_o}, 32'd0);
        check_eq("stop_enable", {31'd0, dec_enable_o}, 32'd0);
        check_eq("stop_on_boundary", seg_out % FRAME, 32'd0);
      end
    end
    check_eq("drain_done", {31'd0, done}, 32'd1);
    check_eq("frame_count", {16'd0, frame_count_o}, exp_frames);
  endtask

  initial begin
    int low;
    int tmo;
    clk = 1'b0;
    n_tests = 0; n_fail = 0;
    core_seq = DW'($urandom);
    seg_base = 0; seg_out = 0; exp_frames = 0; exp_ovf = 0; exp_abort = 0;
    reset_n_i = 1'b0;
    start_i = 1'b0; stop_i = 1'b0; dec_overflow_i = 1'b0;
    dec_pcm_valid_i = 1'b1; dec_pcm_data_i = core_seq; pcm_ready_i = 1'b1;
    #12;
    check_eq("rst_state", {29'd0, state_o}, 32'd0);
    check_eq("rst_enable", {31'd0, dec_enable_o}, 32'd0);
    check_eq("rst_dready", {31'd0, dec_pcm_ready_o}, 32'd0);
    check_eq("rst_pvalid", {31'd0, pcm_valid_o}, 32'd0);
    check_eq("rst_last", {31'd0, pcm_last_o}, 32'd0);
    check_eq("rst_abort", {31'd0, frame_abort_o}, 32'd0);
    check_eq("rst_frames", {16'd0, frame_count_o}, 32'd0);
    check_eq("rst_ovf", {24'd0, ovf_count_o}, 32'd0);
    @(negedge clk);
    reset_n_i = 1'b1;
    run_cycles(3);

    // Settle discard, framing, random back-pressure.
    do_start();
    check_eq("start_settle", {29'd0, state_o}, 32'd1);
    run_cycles(400);
    check_eq("frames_run", {16'd0, frame_count_o}, exp_frames);
    stop_drain(10);

    // Overflow mid-frame.
    do_start();
    wait_idx(20);
    step(1'b0, 1'b0, 1'b1);
    model_overflow();
    check_eq("ovf_pvalid_forced", {31'd0, s_pvalid}, 32'd0);
    check_eq("ovf_dready_forced", {31'd0, s_dready}, 32'd0);
    check_eq("ovf_abort", {31'd0, frame_abort_o}, exp_abort);
    check_eq("ovf_state", {29'd0, state_o}, 32'd4);
    check_eq("ovf_count1", {24'd0, ovf_count_o}, exp_ovf);
    low = 0;
    while (dec_enable_o == 1'b0 && low < 20) begin
      step(1'b0, 1'b0, 1'b0);
      low++;
    end
    check_eq("recover_len", low, RECOV);
    check_eq("abort_pulse_end", {31'd0, frame_abort_o}, 32'd0);
    check_eq("resettle_state", {29'd0, state_o}, 32'd1);
    run_cycles(300);
    check_eq("frames_after_ovf", {16'd0, frame_count_o}, exp_frames);
    stop_drain(10);

    // Overflow ignored while idle; start/stop interplay.
    step(1'b0, 1'b0, 1'b1);
    check_eq("idle_ovf_state", {29'd0, state_o}, 32'd0);
    check_eq("idle_ovf_count", {24'd0, ovf_count_o}, exp_ovf);
    step(1'b1, 1'b1, 1'b0);
    check_eq("start_stop_idle", {29'd0, state_o}, 32'd0);
    do_start();
    check_eq("settle_again", {29'd0, state_o}, 32'd1);
    check_eq("settle_enable", {31'd0, dec_enable_o}, 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check_eq("settle_stop_state", {29'd0, state_o}, 32'd0);
    check_eq("settle_stop_enable", {31'd0, dec_enable_o}, 32'd0);

    // Overflow counter saturation (overflows taken in SETTLE, idx 0).
    do_start();
    tmo = 0;
    for (int i = 0; i < 256; i++) begin
      low = 0;
      while (state_o != 3'd1 && low < 50) begin
        step(1'b0, 1'b0, 1'b0);
        low++;
      end
      if (low >= 50) tmo++;
      step(1'b0, 1'b0, 1'b1);
      model_overflow();
      if (i == 0) check_eq("settle_ovf_no_abort", {31'd0, frame_abort_o}, exp_abort);
    end
    check_eq("sat_wait_in_time", tmo, 32'd0);
    check_eq("ovf_saturated", {24'd0, ovf_count_o}, exp_ovf);

    // Asynchronous reset in the middle of a drain.
    wait_idx(5);
    step(1'b0, 1'b1, 1'b0);
    check_eq("pre_reset_drain", {29'd0, state_o}, 32'd3);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_eq("arst_state", {29'd0, state_o}, 32'd0);
    check_eq("arst_enable", {31'd0, dec_enable_o}, 32'd0);
    check_eq("arst_pvalid", {31'd0, pcm_valid_o}, 32'd0);
    check_eq("arst_dready", {31'd0, dec_pcm_ready_o}, 32'd0);
    check_eq("arst_frames", {16'd0, frame_count_o}, 32'd0);
    check_eq("arst_ovf", {24'd0, ovf_count_o}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
